// File: rtl/alu_pkg.sv
// Shared types and helpers for the ARM-style execute stage: opcodes,
// condition codes and NZCV flag bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } alu_op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Compare ops update flags unconditionally (on pass) and never write Rd.
    function automatic logic is_compare(input alu_op_e op);
        return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
    endfunction

    function automatic logic is_arith(input alu_op_e op);
        return op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN};
    endfunction

endpackage

// File: rtl/alu_flag_stage_cond_check.sv
// Combinational ARM condition-field evaluation against the current NZCV flags.
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // NOTE: default assignment first so no path through the case leaves pass unassigned (no latch).
    always_comb begin
        pass = 1'b0;
        unique case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_stage.sv
// Execute stage: ARM data-processing ALU with architectural NZCV register,
// condition evaluation and a 1-cycle registered result.
module alu_flag_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [3:0]       cond,
    input  logic [3:0]       opcode,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             shifter_carry,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             write_en,
    output logic             cond_pass,
    output logic [3:0]       flags,
    output logic             carry_flag
);

    alu_op_e          op;
    logic             pass_comb;
    logic [WIDTH-1:0] add_x, add_y;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             add_v;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       flags_next;
    logic             flag_update;

    assign op         = alu_op_e'(opcode);
    assign carry_flag = flags[FLAG_C];

    cond_check u_cond_check (
        .cond  (cond),
        .flags (flags),
        .pass  (pass_comb)
    );

    // Subtraction is x + ~y + cin so every arithmetic op shares one adder.
    always_comb begin
        add_x   = a;
        add_y   = b;
        add_cin = 1'b0;
        unique case (op)
            OP_SUB, OP_CMP: begin add_x = a; add_y = ~b; add_cin = 1'b1;             end
            OP_RSB:         begin add_x = b; add_y = ~a; add_cin = 1'b1;             end
            OP_ADC:         begin add_x = a; add_y = b;  add_cin = flags[FLAG_C];    end
            OP_SBC:         begin add_x = a; add_y = ~b; add_cin = flags[FLAG_C];    end
            OP_RSC:         begin add_x = b; add_y = ~a; add_cin = flags[FLAG_C];    end
            default:        begin add_x = a; add_y = b;  add_cin = 1'b0;             end
        endcase
    end

    assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    assign add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

    always_comb begin
        alu_result = sum[WIDTH-1:0];
        unique case (op)
            OP_AND, OP_TST: alu_result = a & b;
            OP_EOR, OP_TEQ: alu_result = a ^ b;
            OP_ORR:         alu_result = a | b;
            OP_MOV:         alu_result = b;
            OP_BIC:         alu_result = a & ~b;
            OP_MVN:         alu_result = ~b;
            default:        alu_result = sum[WIDTH-1:0];
        endcase
    end

    // Logical ops take C from the shifter and leave V alone.
    always_comb begin
        flags_next         = flags;
        flags_next[FLAG_N] = alu_result[WIDTH-1];
        flags_next[FLAG_Z] = (alu_result == '0);
        if (is_arith(op)) begin
            flags_next[FLAG_C] = sum[WIDTH];
            flags_next[FLAG_V] = add_v;
        end else begin
            flags_next[FLAG_C] = shifter_carry;
        end
    end

    assign flag_update = in_valid && pass_comb && (set_flags || is_compare(op));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            write_en  <= 1'b0;
            cond_pass <= 1'b0;
            flags     <= 4'b0000;
        end else if (!stall) begin
            out_valid <= in_valid;
            write_en  <= in_valid && pass_comb && !is_compare(op);
            cond_pass <= in_valid && pass_comb;
            if (in_valid) begin
                result <= alu_result;
            end
            if (flag_update) begin
                flags <= flags_next;
            end
        end
    end

endmodule

// File: doc/alu_flag_stage.md
Name: alu_flag_stage

Overview:
- Execute-stage consumer of the barrel shifter output: combines Rn with the shifted operand2 and shifter carry-out.
- Performs the 16 ARM data-processing operations and evaluates the condition field.
- Owns the architectural NZCV register.
- Registers the result with 1-cycle latency, and feeds the live C flag back to the shifter's carry input for RRX and carry-in use.

Parameters:
- WIDTH, 32, datapath width of operands and result.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- stall  input  1  hold every register this cycle.
- in_valid  input  1  an instruction is presented this cycle.
- cond  input  4  ARM condition field.
- opcode  input  4  ARM data-processing opcode.
- set_flags  input  1  S bit.
- a  input  WIDTH  Rn operand.
- b  input  WIDTH  shifter output (operand2).
- shifter_carry  input  1  shifter carry-out; already equals the C flag when no shift was applied.
- out_valid  output  1  result register holds a completed instruction.
- result  output  WIDTH  registered ALU result.
- write_en  output  1  registered: write result to Rd.
- cond_pass  output  1  registered condition outcome of the instruction in result.
- flags  output  4  NZCV register, bit3 = N, bit0 = V.
- carry_flag  output  1  flags[1], combinational from the register, drives the shifter carry input.

Behaviour:
- **Clock and reset.** Single clock; reset is synchronous, active-high, and has priority over stall.
- **Reset values.** flags=0000, out_valid=0, result=0, write_en=0, cond_pass=0.
- **Stall.** When stall=1 and reset=0, every register holds. Inputs are ignored and no flag update occurs.
- **Latency.** Inputs accepted at edge t appear on result, write_en and cond_pass after edge t, i.e. 1 cycle.
- **Flag update timing.** flags update at the same edge t. An instruction accepted at t+1 sees the updated flags for condition evaluation and carry (back-to-back CMP then Bcc-style use works with no bubble).
- **Condition evaluation.** Combinational, against the current flags register, i.e. before this instruction's own update.
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 0xF (NV) never passes.
- **Opcodes.**
  - 0 AND, 1 EOR, 2 SUB a-b, 3 RSB b-a, 4 ADD, 5 ADC a+b+C, 6 SBC a-b-!C, 7 RSC b-a-!C.
  - 8 TST, 9 TEQ, A CMP, B CMN, C ORR, D MOV b, E BIC a&~b, F MVN ~b.
- **Arithmetic.**
  - Done in WIDTH+1 bits. Subtraction is implemented as x + ~y + cin, with cin=1 for SUB/RSB/CMP and cin=C for SBC/RSC.
  - C = bit WIDTH of the sum, so C=1 means no borrow.
  - V = signed overflow of the adder operands.
- **Flag update rule.** Applies when in_valid & cond_pass_comb & set_flags & !stall & !reset.
  - Arithmetic ops (2–7, A, B): N = result[MSB], Z = (result==0), C and V from the adder.
  - Logical ops (0, 1, 8, 9, C–F): N and Z as above, C = shifter_carry, V unchanged.
- **Compare ops.** TST/TEQ/CMP/CMN always update flags when the condition passes, regardless of set_flags; they never assert write_en.
- **Registered outputs.**
  - write_en = in_valid & cond_pass_comb & opcode not in 8..B.
  - out_valid = in_valid, also asserted when the condition fails; cond_pass reports the failure.
- **Idle cycles.** When in_valid=0 and not stalled: out_valid=0, write_en=0, cond_pass=0, result holds its previous value, flags hold.
- **Failed condition.** result still captures the computed value, but write_en=0 and flags are unchanged.
- **Overflow.** Results wrap modulo 2^WIDTH; there is no saturation.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op_e enum for the 16 opcodes;
  - cond_e enum for the 16 condition codes;
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - helper function is_compare(op).
- One natural combinational sub-module: cond_check (inputs cond and flags, output pass).
- Adder, logic unit and flag register stay in alu_flag_stage.

Test Plan:
- reset, then ADDS AL a=0x7FFFFFFF b=1 -> next cycle: result=0x80000000, write_en=1, out_valid=1, flags=1001.
- SUBS a=5 b=5 -> result=0, flags=0110. Then RSBS a=5 b=3 -> result=0xFFFFFFFE, flags=1000.
- CMP a=3 b=5 (flags -> 1000), next cycle ADD EQ a=1 b=1 -> cond_pass=0, write_en=0, flags stay 1000. Following ADD LT a=1 b=1 -> result=2, write_en=1.
- Set C=1 via CMP 5,5, then ANDS a=0xF0 b=0x0F shifter_carry=0 -> result=0, flags=0100 (V preserved 0, C from shifter). Then ADCS a=0xFFFFFFFF b=0 with C=0 -> result=0xFFFFFFFF, flags=1000.
- With flags C=1: ADCS a=0xFFFFFFFF b=0 -> result=0, flags=0110. carry_flag=1 within the same cycle the flag register updates.
- Stall for 3 cycles during ADDS a=1 b=2 -> result, flags and out_valid frozen. Assert reset while stall=1 -> all outputs return to reset values on the next edge.
